// File: rtl/stack_controller.sv
// Purpose : push/pop sequencer for the 16x8 stack memory; owns the stack pointer, drives the shared memory bus.
// Latency : push busy 1 cycle (write commits on the following edge); pop busy 2 cycles (pop_data/pop_valid on the 2nd edge).
// Backpressure: requests are only sampled while idle (busy=0); requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push, pop, push_data     single-cycle requests from the datapath (push wins if both)
//   pop_data, pop_valid      last popped value, pulse when it updates
//   busy, full, empty, depth status; depth counts occupied slots 0..16
//   err                      one-cycle pulse for push-while-full / pop-while-empty
//   mem_sm/addr/we/re/data   stack memory bus; mem_data driven only while mem_we=1
module stack_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic [4:0] depth,
    output logic       err,
    output logic       mem_sm,
    output logic [3:0] mem_addr,
    output logic       mem_we,
    output logic       mem_re,
    inout  wire  [7:0] mem_data
);

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ_REQ = 2'd2,
        ST_READ_CAP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   wr_buf;
    logic            err_pend;

    // Next values for the registered bus controls
    logic            sm_nxt;
    logic            we_nxt;
    logic            re_nxt;
    logic [AW-1:0]   addr_nxt;

    logic            is_idle;
    logic            acc_push;
    logic            acc_pop;
    logic            bad_req;
    logic [CW-1:0]   depth_m1;

    assign is_idle  = (state == ST_IDLE);
    assign full     = (depth == CW'(DEPTH));
    assign empty    = (depth == '0);
    assign busy     = !is_idle;
    assign depth_m1 = depth - CW'(1);

    // Push has priority; a simultaneous pop is dropped silently. A push
    // against a full stack is an error even when pop is also asserted.
    assign acc_push = is_idle && push && !full;
    assign acc_pop  = is_idle && !push && pop && !empty;
    assign bad_req  = is_idle && ((push && full) || (!push && pop && empty));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (acc_push) begin
                    state_nxt = ST_WRITE;
                end else if (acc_pop) begin
                    state_nxt = ST_READ_REQ;
                end
            end
            ST_WRITE:    state_nxt = ST_IDLE;
            ST_READ_REQ: state_nxt = ST_READ_CAP;
            ST_READ_CAP: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: bus controls are decoded from the state being entered
    // and registered below, so they change only on clock edges. depth is
    // stable while entering WRITE/READ_REQ/READ_CAP, so the address taken
    // here is the slot the whole operation works on.
    // ------------------------------------------------------------------
    always_comb begin
        sm_nxt   = 1'b0;
        we_nxt   = 1'b0;
        re_nxt   = 1'b0;
        addr_nxt = '0;
        case (state_nxt)
            ST_WRITE: begin
                sm_nxt   = 1'b1;
                we_nxt   = 1'b1;
                addr_nxt = depth[AW-1:0];
            end
            ST_READ_REQ, ST_READ_CAP: begin
                sm_nxt   = 1'b1;
                re_nxt   = 1'b1;
                addr_nxt = depth_m1[AW-1:0];
            end
            default: begin
                sm_nxt   = 1'b0;
                we_nxt   = 1'b0;
                re_nxt   = 1'b0;
                addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_sm   <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_sm   <= sm_nxt;
            mem_we   <= we_nxt;
            mem_re   <= re_nxt;
            mem_addr <= addr_nxt;
        end
    end

    // The write buffer is only driven onto the bus while mem_we is high;
    // mem_we is registered and cleared asynchronously, so reset releases
    // the bus immediately.
    assign mem_data = mem_we ? wr_buf : {DW{1'bz}};

    // ------------------------------------------------------------------
    // Datapath: write buffer, stack pointer, pop result, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_buf <= '0;
        end else if (acc_push) begin
            wr_buf <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (state == ST_WRITE) begin
            depth <= depth + CW'(1);
        end else if (state == ST_READ_CAP) begin
            depth <= depth_m1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= (state == ST_READ_CAP);
            if (state == ST_READ_CAP) begin
                pop_data <= mem_data;
            end
        end
    end

    // The error is flagged one edge after the offending request was
    // sampled: the request edge sets err_pend, the following edge raises
    // err for exactly one cycle. Back-to-back bad requests give
    // back-to-back pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            err_pend <= bad_req;
            err      <= err_pend;
        end
    end

endmodule
